uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 57600, serial line rate in bit/s.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-006 SHALL have port data, output, 8, last received byte from the holding register.
REQ-007 SHALL have port valid, output, 1, holding register contains an unread byte.
REQ-008 SHALL have port ready, input, 1, consumer accepts the byte when valid && ready.
REQ-009 SHALL have port frame_err, output, 1, sticky flag: stop bit sampled low.
REQ-010 SHALL have port overrun, output, 1, sticky flag: byte completed while valid still high.
REQ-011 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-012 SHALL derive OS_DIV = CLK_FREQ/(BAUD_RATE*16), with a minimum of 1, and emit a one-clock oversample tick every OS_DIV clocks; one bit period is 16 ticks.
REQ-013 SHALL pass rx through a 2-flop synchronizer reset to 1; all logic uses the synchronized value rx_s.
REQ-014 SHALL implement the states IDLE, START, DATA and STOP, with a 4-bit tick counter and a 3-bit bit index.
REQ-015 IDLE: on rx_s=0, go to START, clear the tick counter, and restart the oversample divider so that ticks are phase-aligned to the falling edge.
REQ-016 START: on tick 7 (mid-bit), if rx_s=0, clear the tick counter and go to DATA; if rx_s=1 (glitch), return to IDLE with no output and no flag change.
REQ-017 DATA: on every 16th tick, sample rx_s into the shift register LSB first; after bit index 7, go to STOP.
REQ-018 STOP: on the 16th tick, sample the stop bit, load data from the shift register, set valid=1, set frame_err if the stop bit is 0, and go to IDLE in the same clock.
REQ-019 A byte with a framing error SHALL still be delivered through data/valid.
REQ-020 If valid=1 and not being accepted in the clock the new byte completes, SHALL set overrun, overwrite data with the new byte, and keep valid=1.
REQ-021 If valid && ready occurs in the same clock as a byte completing, SHALL load the new byte with valid=1 and SHALL NOT set overrun.
REQ-022 valid && ready with no completing byte SHALL clear valid the next clock; data holds its value.
REQ-023 frame_err and overrun SHALL clear only on reset.
REQ-024 A new start bit SHALL be detectable in IDLE on the clock immediately after the STOP sample, so back-to-back frames are received.
REQ-025 rx changes while in DATA or STOP SHALL have no effect except at the sample points.

Reset
REQ-026 On rst=1, asynchronously: state=IDLE, data=8'h00, valid=0, frame_err=0, overrun=0, busy=0, synchronizer flops=1, counters=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no valid pulse; after release, reception resumes at the next falling edge.

Verification
REQ-028 Bench setup SHALL use CLK_FREQ=16_000_000 and BAUD_RATE=1_000_000 (OS_DIV=1, 16 clk per bit).
REQ-029 Scenario, single byte: send 8'hA5 with stop bit 1 and ready=0 -> data=8'hA5, valid=1, frame_err=0, overrun=0 about 9.5 bit times after the start edge; busy low afterwards.
REQ-030 Scenario, framing error: send 8'h3C with stop bit 0 -> data=8'h3C, valid=1, frame_err=1.
REQ-031 Scenario, overrun: send 8'h11 then 8'h22 back-to-back with ready=0 -> data=8'h22, valid=1, overrun=1; repeat with ready=1 held -> overrun=0, two valid pulses.
REQ-032 Scenario, glitch: drive rx low for 4 clk then high -> returns to IDLE, valid stays 0, busy high for at most 8 clk.
REQ-033 Scenario, reset mid-frame: assert rst during DATA bit 3 of 8'hFF -> all outputs at reset values immediately; the following frame 8'h5A is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if -- byte delivery channel out of the UART receiver.
//
// Signals:
//   data  [7:0]  received byte held by the producer
//   valid        producer holds an unread byte in data
//   ready        consumer accepts the byte
//
// Handshake: a transfer happens on every rising clk edge where valid && ready.
// While valid is high and no transfer happens, data stays stable unless a newer
// byte overwrites it (the producer then flags an overrun). valid never depends
// combinationally on ready.
//
// Modports:
//   master -- the receiver (drives data/valid, samples ready)
//   slave  -- the consumer (samples data/valid, drives ready)
interface uart_rx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with 16x oversampling and a one-byte holding
// register.
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz
//   BAUD_RATE  serial line rate in bit/s
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   rx         asynchronous serial line, idle high
//   rxb        uart_rx_if.master: data/valid out, ready in
//   frame_err  sticky: a stop bit was sampled low
//   overrun    sticky: a byte completed while an unread byte was still held
//   busy       receiver is inside a frame (state not IDLE)
//   state_dbg  current receiver state encoding, for observation only
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 57600
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  uart_rx_if.master    rxb,
  output logic         frame_err,
  output logic         overrun,
  output logic         busy,
  output logic [1:0]   state_dbg
);

  // Oversample divider: one tick every OS_DIV clocks, 16 ticks per bit.
  localparam int OS_DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
  localparam int OS_DIV     = (OS_DIV_RAW < 1) ? 1 : OS_DIV_RAW;
  localparam int DIV_W      = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OS_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // Line synchronizer
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Oversample tick generator
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             div_restart;

  assign tick = (div_cnt == DIV_LAST);

  // Restarting on the start edge puts the first tick exactly OS_DIV clocks
  // after the edge, so tick counts line up with bit boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_restart || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Receiver FSM
  state_t     state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       frame_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= 4'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    div_restart = 1'b0;
    frame_done  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d     = ST_START;
          tick_cnt_d  = 4'd0;
          div_restart = 1'b1;
        end
      end

      // Confirm the start bit at its middle; a high line here was a glitch.
      ST_START: begin
        if (tick) begin
          if (tick_cnt_q == 4'd7) begin
            if (!rx_s) begin
              state_d    = ST_DATA;
              tick_cnt_d = 4'd0;
              bit_idx_d  = 3'd0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end

      // Counting from mid start bit, every 16th tick lands mid data bit.
      // The 4-bit counter wraps to 0 on its own after the sample.
      ST_DATA: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shift_d = {rx_s, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_d   = ST_STOP;
              bit_idx_d = 3'd0;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
        end
      end

      // Returning to IDLE right at the stop sample leaves half a bit to spot
      // the next start edge.
      ST_STOP: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            frame_done = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Holding register and sticky flags
  logic [7:0] data_q;
  logic       valid_q;
  logic       frame_err_q;
  logic       overrun_q;

  // A completing byte always wins: it is delivered even with a bad stop bit,
  // and it replaces an unread byte (flagging overrun) unless that byte is
  // being accepted in the same clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (frame_done) begin
      data_q  <= shift_q;
      valid_q <= 1'b1;
      if (!rx_s) begin
        frame_err_q <= 1'b1;
      end
      if (valid_q && !rxb.ready) begin
        overrun_q <= 1'b1;
      end
    end else if (valid_q && rxb.ready) begin
      valid_q <= 1'b0;
    end
  end

  assign rxb.data  = data_q;
  assign rxb.valid = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- self-checking bench for uart_rx at 16 clocks per bit.
//
// The reference model works at frame level: a frame whose start bit is driven
// right after clock edge c completes at edge c+155 (2 synchronizer clocks,
// 1 detect clock, 8 to mid start, 9 x 16 to mid stop) and keeps the receiver
// busy from edge c+3 up to edge c+155. A start glitch keeps it busy from c+3
// to c+11. Holding register / flag rules are applied per clock from those
// events and the sampled ready.
module tb_uart_rx;
  localparam int CLK_FREQ  = 16_000_000;
  localparam int BAUD_RATE = 1_000_000;

  // Clock / reset / DUT
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [1:0] state_dbg;

  uart_rx_if rxb ();

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rxb       (rxb),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Scoreboard state
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_err = 0;
  // {completion edge[31:0], stop bit, byte}
  logic [40:0] exp_q[$];
  logic [40:0] ev;
  logic [7:0]  m_data  = 8'h00;
  logic        m_valid = 1'b0;
  logic        m_fe    = 1'b0;
  logic        m_ov    = 1'b0;
  int unsigned busy_from = 0;
  int unsigned busy_to   = 0;
  int          ready_mode = 0;
  int          valid_rises = 0;
  int          busy_cnt = 0;
  logic        prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model, advanced on every clock edge
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      m_data    = 8'h00;
      m_valid   = 1'b0;
      m_fe      = 1'b0;
      m_ov      = 1'b0;
      busy_from = 0;
      busy_to   = 0;
    end else if (exp_q.size() > 0 && exp_q[0][40:9] == cyc) begin
      ev = exp_q.pop_front();
      if (m_valid && !rxb.ready) m_ov = 1'b1;
      if (!ev[8]) m_fe = 1'b1;
      m_data  = ev[7:0];
      m_valid = 1'b1;
    end else if (m_valid && rxb.ready) begin
      m_valid = 1'b0;
    end
  end

  // Compare process, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      check("data", {24'h0, rxb.data}, {24'h0, m_data});
      check("valid", {31'h0, rxb.valid}, {31'h0, m_valid});
      check("frame_err", {31'h0, frame_err}, {31'h0, m_fe});
      check("overrun", {31'h0, overrun}, {31'h0, m_ov});
      check("busy", {31'h0, busy}, {31'h0, (cyc >= busy_from && cyc < busy_to)});
      if (rxb.valid && !prev_valid) valid_rises++;
      if (busy) busy_cnt++;
      prev_valid = rxb.valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Ready driver: 0 = held low, 1 = held high, otherwise random per clock
  initial begin
    rxb.ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       rxb.ready = 1'b0;
        1:       rxb.ready = 1'b1;
        default: rxb.ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Driver tasks (all start and end 1 time unit after a rising edge)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic abort_reset();
    rst = 1'b1;
    #1;
    check("abort_data", {24'h0, rxb.data}, 32'h0);
    check("abort_valid", {31'h0, rxb.valid}, 32'h0);
    check("abort_frame_err", {31'h0, frame_err}, 32'h0);
    check("abort_overrun", {31'h0, overrun}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    rx = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (3) step();
  endtask

  // Sends one 10-bit frame; abort_at >= 0 resets the DUT at that clock of the
  // frame. A low stop bit is released early enough that the line is high
  // again when the receiver returns to IDLE.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int abort_at);
    int unsigned c;
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    c = cyc;
    exp_q.push_back({32'(c + 155), stop, b});
    busy_from = c + 3;
    busy_to   = c + 155;
    for (int k = 0; k < 160; k++) begin
      if (k == abort_at) begin
        abort_reset();
        return;
      end
      rx = bits[k / 16];
      if (k >= 153) rx = 1'b1;
      step();
    end
  endtask

  task automatic glitch(input int len);
    int unsigned c;
    c = cyc;
    busy_from = c + 3;
    busy_to   = c + 11;
    busy_cnt  = 0;
    rx = 1'b0;
    repeat (len) step();
    rx = 1'b1;
    repeat (14 - len) step();
  endtask

  // Main sequence
  initial begin
    int r;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) step();
    check("reset_data", {24'h0, rxb.data}, 32'h0);
    check("reset_valid", {31'h0, rxb.valid}, 32'h0);
    check("reset_frame_err", {31'h0, frame_err}, 32'h0);
    check("reset_overrun", {31'h0, overrun}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    repeat (2) step();

    // Single byte, ready low
    ready_mode = 0;
    send_frame(8'hA5, 1'b1, -1);
    check("a5_data", {24'h0, rxb.data}, 32'hA5);
    check("a5_valid", {31'h0, rxb.valid}, 32'h1);
    check("a5_frame_err", {31'h0, frame_err}, 32'h0);
    check("a5_overrun", {31'h0, overrun}, 32'h0);
    check("a5_busy", {31'h0, busy}, 32'h0);

    // Framing error
    do_reset();
    send_frame(8'h3C, 1'b0, -1);
    repeat (4) step();
    check("fe_data", {24'h0, rxb.data}, 32'h3C);
    check("fe_valid", {31'h0, rxb.valid}, 32'h1);
    check("fe_frame_err", {31'h0, frame_err}, 32'h1);
    check("fe_overrun", {31'h0, overrun}, 32'h0);

    // Overrun, back-to-back with ready low
    do_reset();
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    check("ov_data", {24'h0, rxb.data}, 32'h22);
    check("ov_valid", {31'h0, rxb.valid}, 32'h1);
    check("ov_overrun", {31'h0, overrun}, 32'h1);
    check("ov_frame_err", {31'h0, frame_err}, 32'h0);

    // Same pair with ready held high
    do_reset();
    ready_mode  = 1;
    valid_rises = 0;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    step();
    check("rdy_overrun", {31'h0, overrun}, 32'h0);
    check("rdy_valid_pulses", 32'(valid_rises), 32'd2);
    check("rdy_data", {24'h0, rxb.data}, 32'h22);
    check("rdy_valid", {31'h0, rxb.valid}, 32'h0);

    // Start glitch of 4 clocks
    do_reset();
    ready_mode = 0;
    glitch(4);
    check("glitch_valid", {31'h0, rxb.valid}, 32'h0);
    check("glitch_busy_max8", {31'h0, (busy_cnt <= 8)}, 32'h1);
    check("glitch_busy_seen", {31'h0, (busy_cnt > 0)}, 32'h1);
    check("glitch_idle", {31'h0, busy}, 32'h0);

    // Reset during DATA bit 3, then a clean frame
    send_frame(8'hFF, 1'b1, 72);
    send_frame(8'h5A, 1'b1, -1);
    check("post_abort_data", {24'h0, rxb.data}, 32'h5A);
    check("post_abort_valid", {31'h0, rxb.valid}, 32'h1);
    check("post_abort_frame_err", {31'h0, frame_err}, 32'h0);
    check("post_abort_overrun", {31'h0, overrun}, 32'h0);

    // Random traffic: bytes, bad stop bits, glitches, gaps, random ready
    do_reset();
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        glitch($urandom_range(1, 6));
      end else begin
        send_frame(8'($urandom_range(0, 255)), (r == 1) ? 1'b0 : 1'b1, -1);
      end
      if ($urandom_range(0, 3) != 0) begin
        repeat ($urandom_range(1, 20)) step();
      end
    end
    repeat (20) step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
